imm_gen_stage: RTL



---
 rtl/imm_gen_stage_if.sv | 32 +++
 rtl/imm_gen_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if
//   Handshake bundle for the immediate-generation stage.
//   Upstream side:   in_valid, in_ready, in_instr[31:0], in_tag[TAG_W-1:0]
//   Downstream side: out_valid, out_ready, out_imm[XLEN-1:0], out_fmt[2:0],
//                    out_sra, out_tag[TAG_W-1:0]
//   modport slave  : the stage itself (consumes instructions, produces results)
//   modport master : the environment around the stage
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_sra;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_sra, out_tag
  );

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_sra, out_tag
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
//   Decodes the immediate of a raw RV instruction and presents it, registered,
//   through a two-entry (main + skid) buffer for full throughput under
//   backpressure.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     flush  - synchronous flush; empties both entries, drops same-cycle input
//     bus    - imm_gen_stage_if.slave (in_* handshake, out_* result)
//   out_fmt: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (zimm), 7 SH (shift).
module imm_gen_stage #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 8,
  parameter int EN_ZICSR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_stage_if.slave bus
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_stage: TAG_W must be at least 1");
  end

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [31:0]      instr_s;
  logic [6:0]       opc_s;
  logic [2:0]       f3_s;
  logic [5:0]       shamt_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [2:0]       dec_fmt_s;
  logic             dec_sra_s;

  logic             main_valid_r, skid_valid_r, in_ready_r;
  logic [XLEN-1:0]  main_imm_r, skid_imm_r;
  logic [2:0]       main_fmt_r, skid_fmt_r;
  logic             main_sra_r, skid_sra_r;
  logic [TAG_W-1:0] main_tag_r, skid_tag_r;

  logic in_fire_s, out_fire_s;
  logic main_valid_nxt_s, skid_valid_nxt_s;
  logic load_main_s, load_skid_s, skid_to_main_s;

  assign instr_s = bus.in_instr;
  assign opc_s   = instr_s[6:0];
  assign f3_s    = instr_s[14:12];
  // RV32 shift amounts are 5 bits; bit 25 only belongs to shamt on RV64.
  assign shamt_s = (XLEN == 64) ? instr_s[25:20] : {1'b0, instr_s[24:20]};

  // Immediate-format classification and extension of the incoming instruction.
  always_comb begin
    dec_imm_s = '0;
    dec_fmt_s = FMT_NONE;
    dec_sra_s = 1'b0;
    case (opc_s)
      OPC_OP_IMM: begin
        if (f3_s == 3'b001 || f3_s == 3'b101) begin
          dec_fmt_s = FMT_SH;
          dec_imm_s = XLEN'(shamt_s);
          dec_sra_s = instr_s[30];
        end else begin
          dec_fmt_s = FMT_I;
          dec_imm_s = XLEN'($signed(instr_s[31:20]));
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec_fmt_s = FMT_I;
        dec_imm_s = XLEN'($signed(instr_s[31:20]));
      end
      OPC_STORE: begin
        dec_fmt_s = FMT_S;
        dec_imm_s = XLEN'($signed({instr_s[31:25], instr_s[11:7]}));
      end
      OPC_BRANCH: begin
        dec_fmt_s = FMT_B;
        dec_imm_s = XLEN'($signed({instr_s[31], instr_s[7], instr_s[30:25],
                                   instr_s[11:8], 1'b0}));
      end
      OPC_JAL: begin
        dec_fmt_s = FMT_J;
        dec_imm_s = XLEN'($signed({instr_s[31], instr_s[19:12], instr_s[20],
                                   instr_s[30:21], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt_s = FMT_U;
        dec_imm_s = XLEN'($signed({instr_s[31:12], 12'h000}));
      end
      OPC_SYSTEM: begin
        // funct3[2] marks the immediate CSR variants (CSRRWI/CSRRSI/CSRRCI).
        if (EN_ZICSR != 0 && f3_s[2]) begin
          dec_fmt_s = FMT_Z;
          dec_imm_s = XLEN'(instr_s[19:15]);
        end else begin
          dec_fmt_s = FMT_NONE;
          dec_imm_s = '0;
        end
      end
      default: begin
        dec_fmt_s = FMT_NONE;
        dec_imm_s = '0;
      end
    endcase
  end

  assign in_fire_s  = bus.in_valid & in_ready_r & ~flush;
  assign out_fire_s = main_valid_r & bus.out_ready;

  // Buffer occupancy control: decides which register loads and the next valid bits.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    skid_to_main_s   = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (out_fire_s) begin
      // in_ready is low whenever skid is full, so in_fire cannot coincide here.
      if (skid_valid_r) begin
        skid_to_main_s   = 1'b1;
        skid_valid_nxt_s = 1'b0;
        main_valid_nxt_s = 1'b1;
      end else if (in_fire_s) begin
        load_main_s      = 1'b1;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else if (in_fire_s) begin
      if (main_valid_r) begin
        load_skid_s      = 1'b1;
        skid_valid_nxt_s = 1'b1;
      end else begin
        load_main_s      = 1'b1;
        main_valid_nxt_s = 1'b1;
      end
    end else begin
      main_valid_nxt_s = main_valid_r;
    end
  end

  // Valid bits and the registered in_ready (mirror of an empty skid).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

  // Main entry payload: fresh decode or promotion from skid, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm_r <= '0;
      main_fmt_r <= 3'd0;
      main_sra_r <= 1'b0;
      main_tag_r <= '0;
    end else if (load_main_s) begin
      main_imm_r <= dec_imm_s;
      main_fmt_r <= dec_fmt_s;
      main_sra_r <= dec_sra_s;
      main_tag_r <= bus.in_tag;
    end else if (skid_to_main_s) begin
      main_imm_r <= skid_imm_r;
      main_fmt_r <= skid_fmt_r;
      main_sra_r <= skid_sra_r;
      main_tag_r <= skid_tag_r;
    end
  end

  // Skid entry payload: captures input arriving while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_r <= '0;
      skid_fmt_r <= 3'd0;
      skid_sra_r <= 1'b0;
      skid_tag_r <= '0;
    end else if (load_skid_s) begin
      skid_imm_r <= dec_imm_s;
      skid_fmt_r <= dec_fmt_s;
      skid_sra_r <= dec_sra_s;
      skid_tag_r <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = main_valid_r;
  assign bus.out_imm   = main_imm_r;
  assign bus.out_fmt   = main_fmt_r;
  assign bus.out_sra   = main_sra_r;
  assign bus.out_tag   = main_tag_r;

endmodule
